// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared AHB constants, default-slave state type and sizing helper for the bus matrix
package ahb_mtx_pkg;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;
  typedef enum logic [1:0] {DFT_IDLE, DFT_ERR1, DFT_ERR2} dft_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ahb_mtx_dft_slave.sv
// ahb_mtx_dft_slave: two-cycle ERROR default slave with saturating unmapped-access counter
module ahb_mtx_dft_slave
  import ahb_mtx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_i,
  input  logic             hready_i,
  input  logic             xfer_i,
  input  logic             cnt_clr_i,
  output logic             ready_o,
  output logic [1:0]       resp_o,
  output logic [CNT_W-1:0] cnt_o
);
  dft_state_e       state_q;
  logic             ready_q;
  logic [1:0]       resp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  assign accept  = sel_i & hready_i & xfer_i;
  assign ready_o = ready_q;
  assign resp_o  = resp_q;
  assign cnt_o   = cnt_q;
  // IDLE and ERR2 both take a new transfer; ERR1 is the mandatory low-ready error cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DFT_IDLE;
      ready_q <= 1'b1;
      resp_q  <= RESP_OKAY;
    end else if (state_q == DFT_ERR1) begin
      state_q <= DFT_ERR2;
      ready_q <= 1'b1;
      resp_q  <= RESP_ERROR;
    end else begin
      state_q <= accept ? DFT_ERR1 : DFT_IDLE;
      ready_q <= ~accept;
      resp_q  <= accept ? RESP_ERROR : RESP_OKAY;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_clr_i ? '0 : (accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
endmodule

// File: rtl/ahb_mtx_dec_param.sv
// ahb_mtx_dec_param: table-driven input-stage decoder with boot remap, data-phase tracking
// and a built-in ERROR default slave for unmapped addresses
module ahb_mtx_dec_param
  import ahb_mtx_pkg::*;
#(
  parameter int                                NUM_PORTS   = 4,
  parameter int                                ADDR_LO     = 10,
  parameter logic [NUM_PORTS*(32-ADDR_LO)-1:0] REGION_BASE = '0,
  parameter logic [NUM_PORTS*(32-ADDR_LO)-1:0] REGION_TOP  = '1,
  parameter bit                                REMAP_EN    = 1'b1,
  parameter int                                REMAP_PORT  = 0,
  parameter int                                DATA_W      = 32,
  parameter int                                RUSER_W     = 32,
  parameter int                                CNT_W       = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           HREADYS,
  input  logic                           sel_dec,
  input  logic [31-ADDR_LO:0]            decode_addr_dec,
  input  logic [1:0]                     trans_dec,
  input  logic                           remap,
  input  logic                           cnt_clr,
  input  logic [NUM_PORTS-1:0]           active_in,
  input  logic [NUM_PORTS-1:0]           readyout_in,
  input  logic [2*NUM_PORTS-1:0]         resp_in,
  input  logic [DATA_W*NUM_PORTS-1:0]    rdata_in,
  input  logic [RUSER_W*NUM_PORTS-1:0]   ruser_in,
  output logic [NUM_PORTS-1:0]           sel_out,
  output logic                           active_dec,
  output logic                           HREADYOUTS,
  output logic [1:0]                     HRESPS,
  output logic [DATA_W-1:0]              HRDATAS,
  output logic [RUSER_W-1:0]             HRUSERS,
  output logic [CNT_W-1:0]               unmapped_cnt
);
  localparam int AW = 32 - ADDR_LO;
  localparam int PW = clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
    if (REGION_BASE[i*AW +: AW] > REGION_TOP[i*AW +: AW]) begin : g_bad_region
      $error("ahb_mtx_dec_param: region %0d base above top", i);
    end
  end
  if (REMAP_PORT < 0 || REMAP_PORT >= NUM_PORTS) begin : g_bad_remap
    $error("ahb_mtx_dec_param: REMAP_PORT %0d out of range", REMAP_PORT);
  end
  logic [NUM_PORTS-1:0] hit;
  logic [PW-1:0]        match_port, addr_port, data_port_q;
  logic                 remap_q, sel_dft, dft_ready;
  logic [1:0]           dft_resp;
  // descending scan so the lowest matching index wins on overlap
  always_comb begin
    hit        = '0;
    match_port = DFT;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      hit[p]     = decode_addr_dec >= REGION_BASE[p*AW +: AW] && decode_addr_dec <= REGION_TOP[p*AW +: AW];
      match_port = hit[p] ? PW'(p) : match_port;
    end
    match_port = (REMAP_EN && remap_q && hit[0]) ? PW'(REMAP_PORT) : match_port;
    addr_port  = (trans_dec == TRANS_IDLE && data_port_q != DFT) ? data_port_q : match_port;
  end
  assign sel_dft = sel_dec && addr_port == DFT;
  always_comb begin
    sel_out    = '0;
    active_dec = 1'b1;
    HREADYOUTS = dft_ready;
    HRESPS     = dft_resp;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_out[p] = sel_dec && addr_port == PW'(p);
      active_dec = (addr_port == PW'(p)) ? active_in[p] : active_dec;
      if (data_port_q == PW'(p)) begin
        HREADYOUTS = readyout_in[p];
        HRESPS     = resp_in[2*p +: 2];
        HRDATAS    = rdata_in[DATA_W*p +: DATA_W];
        HRUSERS    = ruser_in[RUSER_W*p +: RUSER_W];
      end
    end
  end
  // remap only samples outside an active transfer so a burst never changes target
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remap_q     <= 1'b0;
      data_port_q <= DFT;
    end else begin
      if (HREADYS && (!sel_dec || !trans_dec[1])) remap_q <= remap;
      if (HREADYS) data_port_q <= addr_port;
    end
  end
  ahb_mtx_dft_slave #(.CNT_W(CNT_W)) u_dft (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .sel_i     (sel_dft),
    .hready_i  (HREADYS),
    .xfer_i    (trans_dec[1]),
    .cnt_clr_i (cnt_clr),
    .ready_o   (dft_ready),
    .resp_o    (dft_resp),
    .cnt_o     (unmapped_cnt)
  );
endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// tb_ahb_mtx_dec_param: directed stimulus with a per-cycle behavioural model compare
module tb_ahb_mtx_dec_param;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
  localparam logic [31:0] RB [4] = '{32'h2000_0000, 32'h4000_0000, 32'h0000_0000, 32'h4000_8000};
  localparam logic [31:0] RT [4] = '{32'h2000_FFFF, 32'h4000_FFFF, 32'h0000_FFFF, 32'h6FFF_FFFF};
  localparam logic [87:0] P_BASE = {22'(32'h4000_8000 >> 10), 22'(32'h0000_0000 >> 10),
                                    22'(32'h4000_0000 >> 10), 22'(32'h2000_0000 >> 10)};
  localparam logic [87:0] P_TOP  = {22'(32'h6FFF_FFFF >> 10), 22'(32'h0000_FFFF >> 10),
                                    22'(32'h4000_FFFF >> 10), 22'(32'h2000_FFFF >> 10)};
  localparam logic [31:0] UNM = 32'hF000_0000;

  logic         HCLK = 1'b0, HRESETn = 1'b1;
  logic         HREADYS = 1'b1, sel_dec = 1'b0, remap = 1'b0, cnt_clr = 1'b0;
  logic [31:0]  addr = '0;
  logic [1:0]   trans_dec = IDLE;
  logic [3:0]   active_in = 4'b1111, readyout_in = 4'b1111;
  logic [7:0]   resp_in = 8'b00_00_01_00;
  logic [127:0] rdata_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_A5A5};
  logic [127:0] ruser_in = {32'hC3C3_0003, 32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};
  logic [3:0]   sel_out;
  logic         active_dec, HREADYOUTS;
  logic [1:0]   HRESPS;
  logic [31:0]  HRDATAS, HRUSERS;
  logic [7:0]   unmapped_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_mtx_dec_param #(
    .NUM_PORTS(4), .ADDR_LO(10), .REGION_BASE(P_BASE), .REGION_TOP(P_TOP),
    .REMAP_EN(1'b1), .REMAP_PORT(2), .DATA_W(32), .RUSER_W(32), .CNT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(addr[31:10]), .trans_dec(trans_dec), .remap(remap), .cnt_clr(cnt_clr),
    .active_in(active_in), .readyout_in(readyout_in), .resp_in(resp_in),
    .rdata_in(rdata_in), .ruser_in(ruser_in), .sel_out(sel_out), .active_dec(active_dec),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS),
    .unmapped_cnt(unmapped_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // model: data-phase owner (4 = default slave), remap level, error cycles left, counter
  int m_dport = 4, m_err = 0, m_cnt = 0;
  logic m_remap = 1'b0;

  function automatic int region_of(input logic [31:0] a);
    if (m_remap && a >= RB[0] && a <= RT[0]) return 2;
    for (int i = 0; i < 4; i++) if (a >= RB[i] && a <= RT[i]) return i;
    return 4;
  endfunction

  function automatic int aport();
    return (trans_dec == IDLE && m_dport != 4) ? m_dport : region_of(addr);
  endfunction

  function automatic logic accepted();
    return sel_dec && aport() == 4 && HREADYS && trans_dec[1];
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_dport <= 4;
      m_remap <= 1'b0;
      m_err   <= 0;
      m_cnt   <= 0;
    end else begin
      m_err <= (m_err == 2) ? 1 : accepted() ? 2 : 0;
      m_cnt <= cnt_clr ? 0 : accepted() ? ((m_cnt == 255) ? 255 : m_cnt + 1) : m_cnt;
      if (HREADYS && (!sel_dec || !trans_dec[1])) m_remap <= remap;
      if (HREADYS) m_dport <= aport();
    end
  end

  int c_ap;
  logic [3:0] e_sel;
  logic e_act, e_rdy;
  logic [1:0] e_resp;
  logic [31:0] e_rd, e_ru;
  always @(negedge HCLK) begin
    c_ap  = aport();
    e_sel = (sel_dec && c_ap < 4) ? 4'(1 << c_ap) : 4'b0000;
    e_act = (c_ap == 4) ? 1'b1 : active_in[c_ap];
    if (m_dport < 4) begin
      e_rdy  = readyout_in[m_dport];
      e_resp = resp_in[2*m_dport +: 2];
      e_rd   = rdata_in[32*m_dport +: 32];
      e_ru   = ruser_in[32*m_dport +: 32];
    end else begin
      e_rdy  = (m_err != 2);
      e_resp = (m_err != 0) ? 2'b01 : 2'b00;
      e_rd   = '0;
      e_ru   = '0;
    end
    chk("m_sel_out", 32'(sel_out), 32'(e_sel));
    chk("m_active_dec", 32'(active_dec), 32'(e_act));
    chk("m_hreadyouts", 32'(HREADYOUTS), 32'(e_rdy));
    chk("m_hresps", 32'(HRESPS), 32'(e_resp));
    chk("m_hrdatas", HRDATAS, e_rd);
    chk("m_hrusers", HRUSERS, e_ru);
    chk("m_unmapped_cnt", 32'(unmapped_cnt), 32'(m_cnt));
  end

  task automatic put(input logic r, input logic s, input logic [31:0] a, input logic [1:0] t);
    HREADYS = r; sel_dec = s; addr = a; trans_dec = t;
  endtask

  task automatic nx();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #2 HRESETn = 1'b0;
    @(negedge HCLK);
    chk("rst_ready", 32'(HREADYOUTS), 32'd1);
    chk("rst_resp", 32'(HRESPS), 32'd0);
    chk("rst_cnt", 32'(unmapped_cnt), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_rdata", HRDATAS, 32'd0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    // port 0 transfer with three wait states
    put(1, 1, 32'h2000_0400, NS);
    @(negedge HCLK); chk("p0_sel", 32'(sel_out), 32'b0001);
    nx();
    readyout_in[0] = 1'b0;
    put(0, 0, 0, IDLE);
    repeat (3) begin
      @(negedge HCLK);
      chk("p0_wait", 32'(HREADYOUTS), 32'd0);
      chk("p0_rdata", HRDATAS, 32'hA5A5_A5A5);
      nx();
    end
    readyout_in[0] = 1'b1;
    put(1, 0, 0, IDLE);
    @(negedge HCLK); chk("p0_done", 32'(HREADYOUTS), 32'd1);
    nx();
    // overlap resolves to lower index, then response mux from port 1
    put(1, 1, 32'h4000_9000, NS);
    @(negedge HCLK); chk("ovl_sel", 32'(sel_out), 32'b0010);
    nx();
    put(1, 1, 32'h5000_0000, NS);
    @(negedge HCLK); chk("p3_sel", 32'(sel_out), 32'b1000); chk("p1_resp", 32'(HRESPS), 32'b01);
    nx();
    put(1, 1, 32'h0000_0400, NS);
    @(negedge HCLK); chk("p2_sel", 32'(sel_out), 32'b0100);
    nx();
    // hold rule after a port 3 transfer
    put(1, 1, 32'h6000_0000, NS);
    nx();
    active_in = 4'b1000;
    put(1, 1, UNM, IDLE);
    @(negedge HCLK); chk("hold_sel", 32'(sel_out), 32'b1000); chk("hold_act", 32'(active_dec), 32'd1);
    nx();
    active_in = 4'b0000;
    put(1, 1, UNM, IDLE);
    @(negedge HCLK); chk("hold_act0", 32'(active_dec), 32'd0);
    nx();
    active_in = 4'b1111;
    // back-to-back unmapped transfers, then IDLE/BUSY to the same address
    put(1, 1, UNM, NS);
    @(negedge HCLK); chk("unm_sel", 32'(sel_out), 32'd0);
    nx();
    put(0, 1, UNM, NS);
    @(negedge HCLK); chk("e1_rdy", 32'(HREADYOUTS), 32'd0); chk("e1_resp", 32'(HRESPS), 32'b01);
    nx();
    put(1, 1, UNM, NS);
    @(negedge HCLK); chk("e2_rdy", 32'(HREADYOUTS), 32'd1); chk("e2_resp", 32'(HRESPS), 32'b01);
    nx();
    put(0, 0, 0, IDLE);
    @(negedge HCLK); chk("e3_rdy", 32'(HREADYOUTS), 32'd0); chk("e3_resp", 32'(HRESPS), 32'b01);
    nx();
    put(1, 1, UNM, IDLE);
    @(negedge HCLK); chk("e4_rdy", 32'(HREADYOUTS), 32'd1); chk("e4_resp", 32'(HRESPS), 32'b01);
    nx();
    put(1, 1, UNM, BUSY);
    @(negedge HCLK); chk("idle_resp", 32'(HRESPS), 32'b00); chk("cnt_two", 32'(unmapped_cnt), 32'd2);
    nx();
    put(1, 0, 0, IDLE);
    @(negedge HCLK); chk("busy_resp", 32'(HRESPS), 32'b00); chk("cnt_still2", 32'(unmapped_cnt), 32'd2);
    nx();
    // remap asserted mid-burst takes effect only after an IDLE with HREADYS high
    put(1, 1, 32'h2000_0000, NS);
    nx();
    remap = 1'b1;
    put(1, 1, 32'h2000_0400, SEQ);
    @(negedge HCLK); chk("rm_burst", 32'(sel_out), 32'b0001);
    nx();
    put(1, 1, 32'h2000_0800, SEQ);
    @(negedge HCLK); chk("rm_burst2", 32'(sel_out), 32'b0001);
    nx();
    put(0, 0, 0, IDLE);
    nx();
    put(1, 1, 32'h2000_0000, NS);
    @(negedge HCLK); chk("rm_stall", 32'(sel_out), 32'b0001);
    nx();
    put(1, 0, 0, IDLE);
    nx();
    put(1, 1, 32'h2000_0000, NS);
    @(negedge HCLK); chk("rm_on", 32'(sel_out), 32'b0100);
    nx();
    remap = 1'b0;
    put(1, 0, 0, IDLE);
    nx();
    // clear wins over a simultaneous accept, then saturate
    cnt_clr = 1'b1;
    put(1, 1, UNM, NS);
    nx();
    cnt_clr = 1'b0;
    put(0, 1, UNM, NS);
    @(negedge HCLK); chk("clr_win", 32'(unmapped_cnt), 32'd0);
    nx();
    for (int k = 0; k < 256; k++) begin
      put(1, 1, UNM, NS);
      nx();
      put(0, 1, UNM, NS);
      nx();
    end
    @(negedge HCLK); chk("cnt_sat", 32'(unmapped_cnt), 32'hFF);
    put(1, 0, 0, IDLE);
    nx();
    put(1, 0, 0, IDLE);
    @(negedge HCLK); chk("sat_idle", 32'(HRESPS), 32'b00);
    nx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_mtx_dec_param.md
Name: ahb_mtx_dec_param

Overview:
Parametrised input-side decoder for the L1 AHB bus matrix. Maps one input stage's address phase onto NUM_PORTS output stages or an internal default slave, and tracks the data-phase owner for response/read-data muxing.
Adds features the fixed-port decoders lack:
- table-driven regions
- run-time boot remap
- built-in two-cycle ERROR default slave FSM
- saturating unmapped-access counter

Parameters:
NUM_PORTS, 4, number of output stages (1..15)
ADDR_LO, 10, lowest decoded address bit
REGION_BASE, packed NUM_PORTS*(32-ADDR_LO) bits, inclusive lower bound per port, port i in slice i
REGION_TOP, packed NUM_PORTS*(32-ADDR_LO) bits, inclusive upper bound per port
REMAP_EN, 1, enables remap alias
REMAP_PORT, 0, port aliased to region of port 0 when remap active
DATA_W, 32, HRDATA width
RUSER_W, 32, HRUSER width
CNT_W, 8, unmapped counter width

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HREADYS  in  1  input-stage HREADY
sel_dec  in  1  input-stage HSEL
decode_addr_dec  in  32-ADDR_LO  HADDR[31:ADDR_LO]
trans_dec  in  2  HTRANS
remap  in  1  remap request level
cnt_clr  in  1  sync clear of unmapped_cnt
active_in  in  NUM_PORTS  output-stage active flags
readyout_in  in  NUM_PORTS  output-stage HREADYOUT
resp_in  in  2*NUM_PORTS  output-stage HRESP
rdata_in  in  DATA_W*NUM_PORTS  output-stage HRDATA
ruser_in  in  RUSER_W*NUM_PORTS  output-stage HRUSER
sel_out  out  NUM_PORTS  per-port HSEL
active_dec  out  1  active flag of addressed port
HREADYOUTS  out  1  HREADY feedback
HRESPS  out  2  response
HRDATAS  out  DATA_W  read data
HRUSERS  out  RUSER_W  read user data
unmapped_cnt  out  CNT_W  count of default-slave transfers

Behaviour:
Clocking and reset:
- Single clock HCLK; HRESETn is asynchronous, active-low.
- Reset values: data_port_q = DFT (index NUM_PORTS); remap_q = 0; FSM = IDLE; unmapped_cnt = 0.
- Resulting outputs in reset: HREADYOUTS=1, HRESPS=2'b00, HRDATAS=0, HRUSERS=0, sel_out=0.

Address phase (combinational):
- Hold rule: if trans_dec==IDLE and data_port_q!=DFT, addr_port = data_port_q.
- Otherwise addr_port is the first match in this order:
  - REMAP_PORT, when REMAP_EN and remap_q and the address is in port 0's region;
  - lowest-index port i with REGION_BASE[i] <= addr <= REGION_TOP[i];
  - else DFT.
- Overlapping regions resolve to the lowest index.
- sel_out[i] = sel_dec & (addr_port==i). The default slave is selected when sel_dec & (addr_port==DFT).
- active_dec = active_in[addr_port]; forced to 1 for DFT.

Remap register:
- remap_q <= remap only when HREADYS & (~sel_dec | ~trans_dec[1]).
- Remap therefore never changes mid-burst or between address and data phase.

Data phase:
- data_port_q <= addr_port when HREADYS; latency is one cycle.
- When data_port_q=i: HREADYOUTS/HRESPS/HRDATAS/HRUSERS come from port i.
- When data_port_q=DFT: HREADYOUTS/HRESPS come from the FSM; HRDATAS=0, HRUSERS=0.

Default slave FSM (IDLE, ERR1, ERR2):
- accept = sel_dft & HREADYS & trans_dec[1].
- IDLE: ready=1, resp=OKAY. accept -> ERR1.
- ERR1: ready=0, resp=ERROR (2'b01). Always -> ERR2.
- ERR2: ready=1, resp=ERROR. accept -> ERR1 (back-to-back unmapped transfers), else -> IDLE.
- IDLE/BUSY to an unmapped address: zero-wait OKAY, no counter increment.

unmapped_cnt:
- +1 on each accept; saturates at all-ones.
- cnt_clr has priority over increment; cleared value is 0.

Parameter checks:
- Elaboration-time error if any REGION_BASE[i] > REGION_TOP[i].
- Elaboration-time error if REMAP_PORT >= NUM_PORTS.

Decomposition:
Shared package ahb_mtx_pkg holds:
- HTRANS constants (IDLE/BUSY/NONSEQ/SEQ)
- HRESP constants OKAY=2'b00, ERROR=2'b01
- default-slave state typedef
- clog2 helper for port index width

One sub-module, ahb_mtx_dft_slave, contains the FSM plus counter. The decoder itself holds the compare loop, remap register, data_port_q and the muxes.

Test Plan:
- Reset with HREADYS=1, no traffic: HREADYOUTS=1, HRESPS=00, unmapped_cnt=0, sel_out=0000.
- NONSEQ to 0x20000400 with regions {0x20000000-0x2000FFFF, ..}: sel_out=0001 same cycle; next cycle HRDATAS=rdata_in[0] (e.g. 0xA5A5A5A5) and HREADYOUTS follows readyout_in[0] through 3 wait states.
- Two NONSEQ to unmapped 0xF0000000: HREADYOUTS 0,1,0,1 and HRESPS 01 for 4 cycles, unmapped_cnt=2; IDLE to the same address gives OKAY and no increment.
- Assert remap mid-burst: no effect until the first IDLE with HREADYS=1; then NONSEQ to 0x20000000 with REMAP_PORT=2 gives sel_out=0100.
- IDLE following a port-3 transfer: sel_out stays on port 3 (hold rule) while active_dec=active_in[3].
- unmapped_cnt at 0xFF plus accept: stays 0xFF; cnt_clr with simultaneous accept gives 0.
